// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared encodings for the data memory access arbiter.
package dm_arb_pkg;

    // Sequencer states
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] WAIT   = 2'b10;
    localparam logic [1:0] RESP   = 2'b11;

    // Requester identity
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    // Largest supported memory read latency
    localparam int RD_LAT_MAX = 3;

    // Round-robin choice on a tie: whoever was not served last.
    function automatic logic rr_pick(input logic last_owner);
        return (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: two-way requester picker (CPU vs loader).
// Build macro DM_ARB_LDR_PRIO_EN: when defined the loader wins every tie and
// last_owner is ignored; otherwise ties alternate round robin.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_owner,
    output logic valid,
    output logic owner
);

    // Select the owner for the next access from the pending requests.
    always_comb begin
        valid = cpu_req | ldr_req;
        owner = OWN_CPU;
        if (cpu_req && ldr_req) begin
`ifdef DM_ARB_LDR_PRIO_EN
            owner = OWN_LDR;
`else
            owner = rr_pick(last_owner);
`endif
        end else if (ldr_req) begin
            owner = OWN_LDR;
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the single-port data memory between the CPU
// controller and the program/debug loader. Each access is sequenced as
// capture (IDLE) -> one-cycle strobe (ACCESS) -> read wait (WAIT) -> done (RESP).
// Build macro DM_ARB_LDR_PRIO_EN selects fixed loader priority (see dm_arb_pick).
module dm_access_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_done,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rdata,
    output logic          busy
);

    localparam int               CNT_W    = $clog2(RD_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_owner;
    logic             owner;
    logic             cap_we;
    logic [AW-1:0]    cap_addr;
    logic [DW-1:0]    cap_wdata;
    logic [DW-1:0]    cpu_rdata_q;
    logic [DW-1:0]    ldr_rdata_q;
    logic             pick_valid;
    logic             pick_owner;
    logic             wait_last;

    dm_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

    assign wait_last = (state == WAIT) && (cnt == CNT_ONE);

    // Access sequencer: capture the winner's command, strobe, wait out read latency, release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= OWN_LDR;
            owner      <= OWN_CPU;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_owner;
                        if (pick_owner == OWN_LDR) begin
                            cap_we    <= ldr_we;
                            cap_addr  <= ldr_addr;
                            cap_wdata <= ldr_wdata;
                        end else begin
                            cap_we    <= cpu_we;
                            cap_addr  <= cpu_addr;
                            cap_wdata <= cpu_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cap_we) begin
                        state <= RESP;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (wait_last) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data lands in the owner's register on the final wait cycle and is held until its next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else if (wait_last) begin
            if (owner == OWN_LDR) begin
                ldr_rdata_q <= dm_rdata;
            end else begin
                cpu_rdata_q <= dm_rdata;
            end
        end
    end

    assign cpu_gnt   = (state == ACCESS) && (owner == OWN_CPU);
    assign ldr_gnt   = (state == ACCESS) && (owner == OWN_LDR);
    assign cpu_done  = (state == RESP) && (owner == OWN_CPU);
    assign ldr_done  = (state == RESP) && (owner == OWN_LDR);
    assign dm_we     = (state == ACCESS) && cap_we;
    assign dm_addr   = cap_addr;
    assign dm_wdata  = cap_wdata;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign busy      = (state != IDLE);

endmodule
